fifo_burst_reader: RTL and testbench

Read-side consumer for the asynchronous FIFO, clocked in the read domain. On a start request it drains a programmed number of words from the FIFO read port (rd_en/data_out/empty). It forwards them downstream on a valid/ready stream, and a 2-entry skid buffer absorbs downstream backpressure. It is the hardware counterpart of the bench write driver and forms the read end of the FIFO datapath.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/skid_buffer2.sv | 55 +++++
 rtl/fifo_burst_reader.sv | 122 ++++++++++++
 tb/tb_fifo_burst_reader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared widths and read-side burst FSM state encoding for the FIFO datapath.
package fifo_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;
    localparam int LEN_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        ABORT  = 2'd2,
        FINISH = 2'd3
    } rdr_state_t;
endpackage

// File: rtl/skid_buffer2.sv
// Two-entry synchronous FIFO with occupancy output; drains on a valid/ready port.
module skid_buffer2 #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready,
    output logic [1:0]       o_occ
);
    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_occ;
    logic             w_pop;
    logic             w_push;

    assign w_pop   = (r_occ != 2'd0) && i_ready;
    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign w_push  = i_push && ((r_occ != 2'd2) || w_pop);
    assign o_valid = (r_occ != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_occ   = r_occ;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end
endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a programmed burst from the FIFO read port onto a valid/ready stream.
// Stream: a word moves when m_valid && m_ready; m_valid/m_data/m_last hold while stalled.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int LEN_WIDTH  = fifo_pkg::LEN_WIDTH
) (
    input  logic                  clk_rd,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  abort,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [LEN_WIDTH-1:0]  words_out,
    output fifo_pkg::rdr_state_t  o_state
);
    import fifo_pkg::*;

    rdr_state_t           r_state;
    rdr_state_t           w_next;
    logic [LEN_WIDTH-1:0] r_issue_rem;
    logic [LEN_WIDTH-1:0] r_beat_rem;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_words_out;
    logic                 r_inflight;
    logic [1:0]           w_occ;
    logic                 w_xfer;
    logic                 w_last_xfer;
    logic                 w_credit_ok;
    logic                 w_rd_en;
    logic                 w_flush;
    logic                 w_done;
    logic                 w_aborted;

    assign w_xfer      = m_valid && m_ready;
    assign w_last_xfer = w_xfer && (r_beat_rem == LEN_WIDTH'(1));
    // Credit counts the read already in flight so the skid can never overflow.
    assign w_credit_ok = (({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_xfer}));
    assign w_rd_en     = !rst && (r_state == READ) && !abort && !empty &&
                         (r_issue_rem != '0) && w_credit_ok;
    assign w_flush     = (r_state == ABORT) || ((r_state == READ) && abort && !w_last_xfer);

    skid_buffer2 #(.WIDTH(DATA_WIDTH)) u_skid (
        .i_clk       (clk_rd),
        .i_rst       (rst),
        .i_flush     (w_flush),
        .i_push      (r_inflight),
        .i_push_data (data_out),
        .o_valid     (m_valid),
        .o_data      (m_data),
        .i_ready     (m_ready),
        .o_occ       (w_occ)
    );

    always_comb begin
        w_next    = r_state;
        w_done    = 1'b0;
        w_aborted = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = (burst_len == '0) ? FINISH : READ;
            end
            READ: begin
                if (w_last_xfer) w_next = FINISH;
                else if (abort)  w_next = ABORT;
            end
            FINISH: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            ABORT: begin
                if (!r_inflight) begin
                    w_aborted = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_rd) begin
        if (rst) begin
            r_state     <= IDLE;
            r_issue_rem <= '0;
            r_beat_rem  <= '0;
            r_len       <= '0;
            r_words_out <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_rd_en;
            if ((r_state == IDLE) && start) begin
                r_issue_rem <= burst_len;
                r_beat_rem  <= burst_len;
                r_len       <= burst_len;
                r_words_out <= '0;
            end else begin
                if (w_rd_en) r_issue_rem <= r_issue_rem - LEN_WIDTH'(1);
                if (w_xfer) begin
                    if (r_beat_rem != '0)     r_beat_rem  <= r_beat_rem - LEN_WIDTH'(1);
                    if (r_words_out != r_len) r_words_out <= r_words_out + LEN_WIDTH'(1);
                end
            end
        end
    end

    assign rd_en     = w_rd_en;
    assign m_last    = m_valid && (r_beat_rem == LEN_WIDTH'(1));
    assign busy      = (r_state != IDLE);
    assign done      = w_done;
    assign aborted   = w_aborted;
    assign words_out = r_words_out;
    assign o_state   = r_state;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-modelled FIFO, scoreboard on the output stream.
`timescale 1ns/1ps
module tb_fifo_burst_reader;
  import fifo_pkg::*;
  localparam int DW = fifo_pkg::DATA_WIDTH;
  localparam int LW = fifo_pkg::LEN_WIDTH;

  // clock / reset
  logic clk_rd = 1'b0;
  always #5 clk_rd = ~clk_rd;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          abort = 1'b0;
  logic          empty;
  logic [DW-1:0] data_out = '0;
  logic          rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [LW-1:0] words_out;
  rdr_state_t    o_state;

  fifo_burst_reader dut (
    .clk_rd    (clk_rd),
    .rst       (rst),
    .start     (start),
    .burst_len (burst_len),
    .abort     (abort),
    .empty     (empty),
    .data_out  (data_out),
    .rd_en     (rd_en),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .words_out (words_out),
    .o_state   (o_state)
  );

  // FIFO read-port model: data appears the cycle after an accepted rd_en
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  assign empty = (fifo_q.size() == 0);
  always @(posedge clk_rd) begin
    if (rd_en && fifo_q.size() != 0) data_out <= fifo_q.pop_front();
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // monitor / scoreboard
  int cyc = 0, rd_cnt = 0, xfer_cnt = 0, done_cnt = 0, abt_cnt = 0, done_cyc = 0;
  int xfer_cyc_q[$];
  int beats_left = 0;
  bit chk_credit = 1'b0;
  int rd_base = 0, xf_base = 0;
  logic prev_stall = 1'b0, prev_last = 1'b0, prev_disturb = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk_rd) begin
    logic xfer;
    cyc++;
    xfer = m_valid && m_ready;
    if (rd_en) begin
      check("rd_while_empty", {31'd0, empty}, 32'd0);
      if (chk_credit)
        check("credit", {31'd0, ((rd_cnt + 1 - rd_base) - (xfer_cnt + int'(xfer) - xf_base)) <= 2}, 32'd1);
      rd_cnt++;
    end
    if (prev_stall && !prev_disturb) begin
      check("stall_valid", {31'd0, m_valid}, 32'd1);
      check("stall_data", {24'd0, m_data}, {24'd0, prev_data});
      check("stall_last", {31'd0, m_last}, {31'd0, prev_last});
    end
    if (xfer) begin
      if (exp_q.size() == 0) check("sb_underrun", 32'd1, 32'd0);
      else check("m_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
      check("m_last", {31'd0, m_last}, {31'd0, beats_left == 1});
      beats_left--;
      xfer_cyc_q.push_back(cyc);
      xfer_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (aborted) abt_cnt++;
    prev_stall   = m_valid && !m_ready;
    prev_data    = m_data;
    prev_last    = m_last;
    prev_disturb = abort || rst;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_rd);
    #1;
  endtask

  task automatic fifo_write(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(DW'(base + DW'(i)));
      exp_q.push_back(DW'(base + DW'(i)));
    end
  endtask

  task automatic start_burst(input int len);
    start      = 1'b1;
    burst_len  = LW'(len);
    beats_left = len;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int limit);
    int n = 0;
    while (done_cnt == d0 && n < limit) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, done_cnt > d0}, 32'd1);
  endtask

  initial begin
    int d0, x0, a0, rd0, lat, n;

    // reset state
    tick(); tick();
    @(negedge clk_rd);
    check("rst_rd_en", {31'd0, rd_en}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_words_out", {24'd0, words_out}, 32'd0);
    check("rst_state", {30'd0, o_state}, {30'd0, IDLE});
    tick();
    rst = 1'b0;
    tick();

    // T1: full-rate burst of 8
    fifo_write(8'h10, 8);
    m_ready = 1'b1;
    d0 = done_cnt; x0 = xfer_cnt;
    start_burst(8);
    wait_done("t1", d0, 40);
    tick();
    check("t1_count", xfer_cnt - x0, 32'd8);
    if (xfer_cnt - x0 == 8) begin
      check("t1_span", xfer_cyc_q[x0 + 7] - xfer_cyc_q[x0], 32'd7);
      check("t1_done_lat", done_cyc - xfer_cyc_q[x0 + 7], 32'd1);
    end
    check("t1_words_out", {24'd0, words_out}, 32'd8);
    check("t1_done_pulses", done_cnt - d0, 32'd1);

    // T2: toggling backpressure
    fifo_write(8'h10, 8);
    chk_credit = 1'b1; rd_base = rd_cnt; xf_base = xfer_cnt;
    d0 = done_cnt; x0 = xfer_cnt;
    start_burst(8);
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      m_ready = (n % 3 == 0);
      tick();
      n++;
    end
    check("t2_done_seen", {31'd0, done_cnt > d0}, 32'd1);
    chk_credit = 1'b0;
    m_ready = 1'b1;
    tick();
    check("t2_count", xfer_cnt - x0, 32'd8);
    check("t2_words_out", {24'd0, words_out}, 32'd8);

    // T3: FIFO runs empty mid-burst
    fifo_write(8'h20, 3);
    d0 = done_cnt; x0 = xfer_cnt;
    start_burst(5);
    repeat (20) tick();
    check("t3_partial", xfer_cnt - x0, 32'd3);
    check("t3_busy", {31'd0, busy}, 32'd1);
    check("t3_words_mid", {24'd0, words_out}, 32'd3);
    fifo_write(8'h23, 2);
    wait_done("t3", d0, 40);
    tick();
    check("t3_count", xfer_cnt - x0, 32'd5);
    check("t3_words_out", {24'd0, words_out}, 32'd5);

    // T4: zero-length burst
    d0 = done_cnt; rd0 = rd_cnt;
    start_burst(0);
    lat = 0;
    while (done_cnt == d0 && lat < 10) begin
      tick();
      lat++;
    end
    tick(); tick();
    check("t4_done_lat", {31'd0, lat >= 1 && lat <= 2}, 32'd1);
    check("t4_done_pulses", done_cnt - d0, 32'd1);
    check("t4_no_reads", rd_cnt - rd0, 32'd0);
    check("t4_words_out", {24'd0, words_out}, 32'd0);

    // T5: abort after 4 transfers with downstream stalled
    fifo_write(8'h40, 12);
    m_ready = 1'b1;
    d0 = done_cnt; x0 = xfer_cnt; a0 = abt_cnt;
    start_burst(10);
    n = 0;
    while (xfer_cnt - x0 < 4 && n < 50) begin
      tick();
      n++;
    end
    m_ready = 1'b0;
    tick();
    abort = 1'b1;
    rd0 = rd_cnt;
    tick();
    abort = 1'b0;
    @(negedge clk_rd);
    check("t5_valid_drop", {31'd0, m_valid}, 32'd0);
    tick();
    n = 0;
    while (abt_cnt == a0 && n < 10) begin
      tick();
      n++;
    end
    tick();
    check("t5_aborted", abt_cnt - a0, 32'd1);
    check("t5_no_done", done_cnt - d0, 32'd0);
    check("t5_no_reads", rd_cnt - rd0, 32'd0);
    check("t5_count", xfer_cnt - x0, 32'd4);
    check("t5_words_out", {24'd0, words_out}, 32'd4);
    check("t5_fifo_left", fifo_q.size(), 32'd6);
    check("t5_state", {30'd0, o_state}, {30'd0, IDLE});
    exp_q = fifo_q;

    // T6: reset mid-burst, then a fresh short burst
    fifo_write(8'h60, 4);
    m_ready = 1'b1;
    x0 = xfer_cnt;
    start_burst(8);
    n = 0;
    while (xfer_cnt - x0 < 3 && n < 50) begin
      tick();
      n++;
    end
    rst = 1'b1;
    m_ready = 1'b0;
    tick();
    @(negedge clk_rd);
    check("t6_state", {30'd0, o_state}, {30'd0, IDLE});
    check("t6_rd_en", {31'd0, rd_en}, 32'd0);
    check("t6_m_valid", {31'd0, m_valid}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_done", {31'd0, done}, 32'd0);
    check("t6_words_out", {24'd0, words_out}, 32'd0);
    tick();
    rst = 1'b0;
    exp_q = fifo_q;
    m_ready = 1'b1;
    tick();
    d0 = done_cnt; x0 = xfer_cnt;
    start_burst(2);
    wait_done("t6", d0, 40);
    tick();
    check("t6_count", xfer_cnt - x0, 32'd2);
    check("t6_words_after", {24'd0, words_out}, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
